picomips_div: RTL and testbench

Iterative signed fractional divider for the picoMIPS datapath, the inverse of the ALU's Q1.7 multiply. The ALU multiply returns (a·b)>>7. This block returns (a<<7)/b, so a Q1.7 product can be divided back by a Q1.7 operand. It sits beside the ALU on the register-file read ports and uses a start/busy/done handshake, because the operation takes a fixed number of cycles. The controller stalls the PC while busy is high and writes the result back when done is high.

---
 rtl/picomips_div.sv | 121 ++++++++++++
 tb/tb_picomips_div.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/picomips_div.sv
// Iterative signed fractional divider: result = sat(trunc((a << (n-1)) / b)) in Q1.(n-1).
// Restoring shift-subtract on magnitudes, one quotient bit per cycle, fixed latency.
module picomips_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(2 * n);

  localparam logic [2*n-2:0] POS_LIM = {{n{1'b0}}, {(n-1){1'b1}}};
  localparam logic [2*n-2:0] NEG_LIM = {{(n-1){1'b0}}, 1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0]   MAX_Q   = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0]   MIN_Q   = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*n-2:0] dvd;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [n-1:0]   rem;
  logic [n-1:0]   bm;
  logic           sgn;
  logic           a_neg;
  logic           dz;

  logic [n-1:0]   am;
  logic [n-1:0]   bmag;
  logic [n:0]     part;
  logic [n:0]     diff;
  logic [n-1:0]   fix_res;
  logic           fix_v;

  always_comb begin
    am   = a[n-1] ? -a : a;
    bmag = b[n-1] ? -b : b;
    part = {rem, dvd[2*n-2]};
    diff = part - {1'b0, bm};
  end

  // Saturation is judged on the magnitude; the negative side may reach 2^(n-1).
  always_comb begin
    fix_res = dvd[n-1:0];
    fix_v   = 1'b0;
    if (dz) begin
      fix_v   = 1'b1;
      fix_res = a_neg ? MIN_Q : MAX_Q;
    end else if (sgn && (dvd != '0)) begin
      if (dvd > NEG_LIM) begin
        fix_v   = 1'b1;
        fix_res = MIN_Q;
      end else begin
        fix_res = -dvd[n-1:0];
      end
    end else if (dvd > POS_LIM) begin
      fix_v   = 1'b1;
      fix_res = MAX_Q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
      dvd    <= '0;
      rem    <= '0;
      bm     <= '0;
      sgn    <= 1'b0;
      a_neg  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= {am, {(n-1){1'b0}}};
            rem   <= '0;
            bm    <= bmag;
            sgn   <= a[n-1] ^ b[n-1];
            a_neg <= a[n-1];
            dz    <= (b == '0);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= diff[n] ? part[n-1:0] : diff[n-1:0];
          dvd <= {dvd[2*n-3:0], ~diff[n]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(2 * n - 2))
            state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          flags  <= {fix_v, fix_res[n-1], (fix_res == '0), dz};
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picomips_div.sv
// Scoreboard bench for picomips_div: stimulus queues expected result/flags/accept cycle,
// a monitor checks every done pulse against the queue head.
module tb_picomips_div;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_bad;

  picomips_div #(.n(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per done pulse, latency measured from the start cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result",  int'(result), int'(e.res));
          check("flags",   int'(flags),  int'(e.flg));
          check("latency", cyc - e.t0,   17);
        end
      end
    end
  end

  task automatic do_div(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] r, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    e.res = r; e.flg = f; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_result", int'(result), 0);
    check("rst_flags",  int'(flags),  0);
    reset = 1'b0;

    // flags = {V, N, Z, D}
    do_div(8'h20, 8'h40, 8'h40, 4'b0000);
    do_div(8'h40, 8'h60, 8'h55, 4'b0000);
    do_div(8'hE0, 8'h40, 8'hC0, 4'b0100);
    do_div(8'hFF, 8'h7F, 8'hFF, 4'b0100);
    do_div(8'h00, 8'h33, 8'h00, 4'b0010);
    do_div(8'h40, 8'h20, 8'h7F, 4'b1000);
    do_div(8'hC0, 8'h20, 8'h80, 4'b1100);
    do_div(8'hC0, 8'h40, 8'h80, 4'b0100);
    do_div(8'h80, 8'h80, 8'h7F, 4'b1000);
    do_div(8'h10, 8'h00, 8'h7F, 4'b1001);
    do_div(8'h90, 8'h00, 8'h80, 4'b1101);
    do_div(8'h00, 8'h00, 8'h7F, 4'b1001);

    // start held high: accepts every 18 cycles, never in DONE
    @(negedge clk);
    a = 8'h40;
    b = 8'h60;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.res = 8'h55; e.flg = 4'b0000; e.t0 = cyc + 18 * i;
      sb.push_back(e);
    end
    repeat (37) @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);

    // operands change and start pulses mid-operation
    @(negedge clk);
    a = 8'h20;
    b = 8'h40;
    start = 1'b1;
    e.res = 8'h40; e.flg = 4'b0000; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 8'hC0;
    b = 8'h20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // reset at cycle 8 of a division discards it
    @(negedge clk);
    a = 8'h40;
    b = 8'h60;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy",   int'(busy),   0);
    check("midrst_done",   int'(done),   0);
    check("midrst_result", int'(result), 0);
    check("midrst_flags",  int'(flags),  0);
    reset = 1'b0;
    do_div(8'hE0, 8'h40, 8'hC0, 4'b0100);
    repeat (20) @(negedge clk);

    check("pending_results", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
